gestor_modos: RTL and testbench

Front-end controller for the digital clock: owns the four shared push-buttons and the two mode switches and turns them into clean, single-cycle, mode-tagged events. It debounces and synchronizes every raw input and commits mode changes only when safe. Events go to exactly one consumer: clock-set, alarm-set or timer. While an alarm or timer expiry is pending, button presses act as acknowledges instead of edits. It sits between the board I/O and the time, alarm and timer datapaths, replacing their direct button connections.

---
 rtl/gestor_modos_pkg.sv | 37 +++
 rtl/gestor_modos_if.sv | 27 ++
 rtl/gestor_modos_antirrebote.sv | 53 +++++
 rtl/gestor_modos.sv | 197 +++++++++++++++++++
 tb/tb_gestor_modos.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/gestor_modos_pkg.sv
// gestor_modos_pkg: shared types and constants for the mode/button front-end.
package gestor_modos_pkg;

  typedef enum logic [1:0] {
    RELOJ        = 2'b00,
    AJ_HORA      = 2'b01,
    ALARMA       = 2'b10,
    TEMPORIZADOR = 2'b11
  } modo_t;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    CAMBIO = 2'b01,
    ALERTA = 2'b10
  } estado_t;

  localparam int NUM_BTN = 4;
  localparam int BTN_EST = 0;
  localparam int BTN_CAM = 1;
  localparam int BTN_INC = 2;
  localparam int BTN_DEC = 3;
  localparam int SW1     = 4;
  localparam int SW2     = 5;
  localparam int NUM_IN  = 6;

  // One-hot pick of the winning rise: est > cam > inc > dec.
  function automatic logic [NUM_BTN-1:0] primer_boton(input logic [NUM_BTN-1:0] sube);
    logic [NUM_BTN-1:0] r;
    r = '0;
    if (sube[BTN_EST])      r[BTN_EST] = 1'b1;
    else if (sube[BTN_CAM]) r[BTN_CAM] = 1'b1;
    else if (sube[BTN_INC]) r[BTN_INC] = 1'b1;
    else if (sube[BTN_DEC]) r[BTN_DEC] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/gestor_modos_if.sv
// gestor_modos_if: board-side raw inputs and datapath-side event outputs.
interface gestor_modos_if;
  import gestor_modos_pkg::*;

  logic  switch1, switch2;
  logic  incrementar, decrementar, cambiar, establecer;
  logic  alarm_req, timer_req;
  modo_t modo;
  logic  evt_inc, evt_dec, evt_cam, evt_est;
  modo_t evt_dst;
  logic  ack_alarma, ack_timer;
  logic  bloqueo;

  modport slave (
    input  switch1, switch2, incrementar, decrementar, cambiar, establecer,
    input  alarm_req, timer_req,
    output modo, evt_inc, evt_dec, evt_cam, evt_est, evt_dst,
    output ack_alarma, ack_timer, bloqueo
  );

  modport master (
    output switch1, switch2, incrementar, decrementar, cambiar, establecer,
    output alarm_req, timer_req,
    input  modo, evt_inc, evt_dec, evt_cam, evt_est, evt_dst,
    input  ack_alarma, ack_timer, bloqueo
  );
endinterface

// File: rtl/gestor_modos_antirrebote.sv
// gestor_modos_antirrebote: 2-FF synchronizer followed by a down-counting
// debounce window; the level flips after DB consecutive differing cycles.
module gestor_modos_antirrebote #(
  parameter int DB = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic nivel_o,
  output logic sube_o
);
  localparam int DB_EFF = (DB < 1) ? 1 : DB;
  localparam int CW     = (DB_EFF > 1) ? $clog2(DB_EFF) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DB_EFF - 1);

  logic          sync1_q, sync2_q;
  logic          nivel_q, sube_q;
  logic [CW-1:0] cnt_q;

  // Bring the raw pin into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Reload while stable; flip the level when the window runs out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nivel_q <= 1'b0;
      sube_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sube_q <= 1'b0;
      if (sync2_q == nivel_q) begin
        cnt_q <= CNT_TC;
      end else if (cnt_q == '0) begin
        nivel_q <= sync2_q;
        sube_q  <= sync2_q;
        cnt_q   <= CNT_TC;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign nivel_o = nivel_q;
  assign sube_o  = sube_q;
endmodule

// File: rtl/gestor_modos.sv
// gestor_modos: debounced, mode-tagged button events for the clock front-end.
// Optional inc/dec auto-repeat is compiled in with AUTO_REPEAT_EN.
//
// state  | meaning
// NORMAL | buttons produce events tagged with modo
// CAMBIO | switches differ from modo; commit once all buttons are released
// ALERTA | alarm/timer pending; first press acknowledges, then wait release
module gestor_modos
  import gestor_modos_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 500
) (
  input  logic          clk,
  input  logic          reset,
  gestor_modos_if.slave bus
);
  localparam int DB = CLK_HZ / 1000 * DEBOUNCE_MS;

  logic [NUM_IN-1:0]  raw, nivel, sube;
  logic [NUM_BTN-1:0] btn_lvl, btn_rise, sel;
  modo_t              sw_modo;
  logic               any_held, others_held, req;
  logic               unused_sw_sube;

  estado_t            estado_q, estado_d;
  modo_t              modo_q, modo_d, dst_q, dst_d;
  logic [NUM_BTN-1:0] evt_q, evt_d;
  logic               ack_al_q, ack_al_d, ack_tm_q, ack_tm_d;
  logic               acked_q, acked_d;

  assign raw[BTN_EST] = bus.establecer;
  assign raw[BTN_CAM] = bus.cambiar;
  assign raw[BTN_INC] = bus.incrementar;
  assign raw[BTN_DEC] = bus.decrementar;
  assign raw[SW1]     = bus.switch1;
  assign raw[SW2]     = bus.switch2;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ar
    gestor_modos_antirrebote #(.DB(DB)) u_ar (
      .clk     (clk),
      .rst     (reset),
      .raw_i   (raw[g]),
      .nivel_o (nivel[g]),
      .sube_o  (sube[g])
    );
  end

  assign btn_lvl        = nivel[NUM_BTN-1:0];
  assign btn_rise       = sube[NUM_BTN-1:0];
  assign sw_modo        = modo_t'({nivel[SW2], nivel[SW1]});
  assign unused_sw_sube = ^sube[NUM_IN-1:NUM_BTN];
  assign any_held       = |btn_lvl;
  // A rise only counts as a fresh press if nothing else was already down.
  assign others_held    = |(btn_lvl & ~btn_rise);
  assign req            = bus.alarm_req | bus.timer_req;
  assign sel            = primer_boton(btn_rise);

`ifdef AUTO_REPEAT_EN
  localparam int RD     = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RR     = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int RD_EFF = (RD < 1) ? 1 : RD;
  localparam int RR_EFF = (RR < 1) ? 1 : RR;
  localparam int RMAX   = (RD_EFF > RR_EFF) ? RD_EFF : RR_EFF;
  localparam int RCW    = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] RD_TC = RCW'(RD_EFF - 1);
  localparam logic [RCW-1:0] RR_TC = RCW'(RR_EFF - 1);

  logic           rep_act_q, rep_act_d, rep_dec_q, rep_dec_d, rep_held;
  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;

  assign rep_held = rep_dec_q ? btn_lvl[BTN_DEC] : btn_lvl[BTN_INC];

  // Auto-repeat bookkeeping: active flag, which button, down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_act_q <= 1'b0;
      rep_dec_q <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      rep_act_q <= rep_act_d;
      rep_dec_q <= rep_dec_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{REPEAT_DELAY_MS[0], REPEAT_RATE_MS[0]};
`endif

  // FSM state, committed mode and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= NORMAL;
      modo_q   <= RELOJ;
      dst_q    <= RELOJ;
      evt_q    <= '0;
      ack_al_q <= 1'b0;
      ack_tm_q <= 1'b0;
      acked_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      dst_q    <= dst_d;
      evt_q    <= evt_d;
      ack_al_q <= ack_al_d;
      ack_tm_q <= ack_tm_d;
      acked_q  <= acked_d;
    end
  end

  // Next state, mode commit, events and acknowledges.
  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    dst_d    = modo_q;
    evt_d    = '0;
    ack_al_d = 1'b0;
    ack_tm_d = 1'b0;
    acked_d  = acked_q;
`ifdef AUTO_REPEAT_EN
    rep_act_d = 1'b0;
    rep_dec_d = rep_dec_q;
    rep_cnt_d = rep_cnt_q;
`endif
    unique case (estado_q)
      NORMAL: begin
        if (req && !any_held) begin
          estado_d = ALERTA;
          acked_d  = 1'b0;
        end else if (sw_modo != modo_q) begin
          estado_d = CAMBIO;
          if (!any_held) modo_d = sw_modo;
        end else if (|btn_rise && !others_held) begin
          if (modo_q != RELOJ) begin
            evt_d = sel;
`ifdef AUTO_REPEAT_EN
            if (sel[BTN_INC] || sel[BTN_DEC]) begin
              rep_act_d = 1'b1;
              rep_dec_d = sel[BTN_DEC];
              rep_cnt_d = RD_TC;
            end
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        else if (rep_act_q && rep_held) begin
          rep_act_d = 1'b1;
          if (rep_cnt_q == '0) begin
            if (rep_dec_q) evt_d[BTN_DEC] = 1'b1;
            else           evt_d[BTN_INC] = 1'b1;
            rep_cnt_d = RR_TC;
          end else begin
            rep_cnt_d = rep_cnt_q - 1'b1;
          end
        end
`endif
      end
      CAMBIO: begin
        if (req && !any_held) begin
          estado_d = ALERTA;
          acked_d  = 1'b0;
        end else if (sw_modo == modo_q) begin
          estado_d = NORMAL;
        end else if (!any_held) begin
          modo_d = sw_modo;
        end
      end
      ALERTA: begin
        if (!acked_q) begin
          if (|btn_rise) begin
            ack_al_d = bus.alarm_req;
            ack_tm_d = bus.timer_req;
            acked_d  = 1'b1;
          end else if (!req) begin
            estado_d = NORMAL;
          end
        end else if (!any_held) begin
          estado_d = NORMAL;
        end
      end
      default: estado_d = NORMAL;
    endcase
  end

  assign bus.modo       = modo_q;
  assign bus.evt_dst    = dst_q;
  assign bus.evt_inc    = evt_q[BTN_INC];
  assign bus.evt_dec    = evt_q[BTN_DEC];
  assign bus.evt_cam    = evt_q[BTN_CAM];
  assign bus.evt_est    = evt_q[BTN_EST];
  assign bus.ack_alarma = ack_al_q;
  assign bus.ack_timer  = ack_tm_q;
  assign bus.bloqueo    = (estado_q == CAMBIO);
endmodule

// File: tb/tb_gestor_modos.sv
// tb_gestor_modos: directed stimulus with hand-computed expectations
// (DB=10, RD=50, RR=20).
`timescale 1ns/1ps
module tb_gestor_modos;
  logic clk = 1'b0;
  logic reset;
  gestor_modos_if ifc();

  gestor_modos #(
    .CLK_HZ          (10_000),
    .DEBOUNCE_MS     (1),
    .REPEAT_DELAY_MS (5),
    .REPEAT_RATE_MS  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_inc = 0, n_dec = 0, n_cam = 0, n_est = 0;

  // Strobe tallies, sampled away from the active edge.
  always @(negedge clk) begin
    if (ifc.evt_inc === 1'b1) n_inc++;
    if (ifc.evt_dec === 1'b1) n_dec++;
    if (ifc.evt_cam === 1'b1) n_cam++;
    if (ifc.evt_est === 1'b1) n_est++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int   b_inc, b_dec, b_cam, b_est, errs;
    logic exp_rep;

    reset = 1'b1;
    ifc.switch1 = 1'b0; ifc.switch2 = 1'b0;
    ifc.incrementar = 1'b0; ifc.decrementar = 1'b0;
    ifc.cambiar = 1'b0; ifc.establecer = 1'b0;
    ifc.alarm_req = 1'b0; ifc.timer_req = 1'b0;
    tick(3);
    chk("rst_modo", 32'(ifc.modo), 0);
    chk("rst_outs", 32'({ifc.evt_inc, ifc.evt_dec, ifc.evt_cam, ifc.evt_est,
                         ifc.ack_alarma, ifc.ack_timer, ifc.bloqueo}), 0);
    reset = 1'b0;

    // RELOJ swallows presses
    ifc.cambiar = 1'b1; tick(20);
    chk("reloj_swallow", 32'(n_cam), 0);
    ifc.cambiar = 1'b0; tick(15);

    // switches 01 with no button held: commit DB+3 after the edge
    ifc.switch1 = 1'b1;
    tick(12); chk("sw01_pre", 32'(ifc.modo), 0);
    tick(1);  chk("sw01_commit", 32'(ifc.modo), 1);
              chk("sw01_bloqueo", 32'(ifc.bloqueo), 1);
    tick(1);  chk("sw01_bloqueo_clr", 32'(ifc.bloqueo), 0);

    // incrementar bounces 4 times, then stable: event 13 cycles later
    b_inc = n_inc;
    for (int i = 0; i < 4; i++) begin
      ifc.incrementar = 1'b1; tick(2);
      ifc.incrementar = 1'b0; tick(2);
    end
    ifc.incrementar = 1'b1;
    tick(12); chk("inc_early", 32'(ifc.evt_inc), 0);
              chk("inc_bounce_none", n_inc - b_inc, 0);
    tick(1);  chk("inc_evt", 32'(ifc.evt_inc), 1);
              chk("inc_dst", 32'(ifc.evt_dst), 1);
    tick(1);  chk("inc_one_cycle", 32'(ifc.evt_inc), 0);
    ifc.incrementar = 1'b0; tick(15);
    chk("inc_count", n_inc - b_inc, 1);

    // mode 10, est and dec coincide; cam pressed while held is ignored
    ifc.switch1 = 1'b0; ifc.switch2 = 1'b1; tick(16);
    chk("sw10", 32'(ifc.modo), 2);
    b_est = n_est; b_dec = n_dec; b_cam = n_cam;
    ifc.establecer = 1'b1; ifc.decrementar = 1'b1;
    tick(13); chk("coinc_est", 32'(ifc.evt_est), 1);
              chk("coinc_dec", 32'(ifc.evt_dec), 0);
              chk("coinc_dst", 32'(ifc.evt_dst), 2);
    ifc.cambiar = 1'b1; tick(60);
    chk("coinc_est_cnt", n_est - b_est, 1);
    chk("coinc_dec_cnt", n_dec - b_dec, 0);
    chk("held_cam_cnt", n_cam - b_cam, 0);
    ifc.establecer = 1'b0; ifc.decrementar = 1'b0; ifc.cambiar = 1'b0; tick(15);

    // switches 01 -> 11 while cambiar held
    ifc.switch1 = 1'b1; ifc.switch2 = 1'b0; tick(16);
    chk("sw01b", 32'(ifc.modo), 1);
    ifc.cambiar = 1'b1; tick(14);
    b_cam = n_cam;
    ifc.switch2 = 1'b1;
    tick(13); chk("chg_bloqueo", 32'(ifc.bloqueo), 1);
              chk("chg_hold_modo", 32'(ifc.modo), 1);
    tick(20);
    ifc.cambiar = 1'b0;
    tick(12); chk("chg_pre_commit", 32'(ifc.modo), 1);
              chk("chg_bloqueo_held", 32'(ifc.bloqueo), 1);
    tick(1);  chk("chg_commit", 32'(ifc.modo), 3);
    tick(1);  chk("chg_bloqueo_clr", 32'(ifc.bloqueo), 0);
              chk("chg_no_evt", n_cam - b_cam, 0);

    // alarm and timer pending: press acknowledges both
    b_inc = n_inc;
    ifc.alarm_req = 1'b1; ifc.timer_req = 1'b1; ifc.incrementar = 1'b1;
    tick(13); chk("alr_ack_a", 32'(ifc.ack_alarma), 1);
              chk("alr_ack_t", 32'(ifc.ack_timer), 1);
              chk("alr_no_evt", 32'(ifc.evt_inc), 0);
    tick(1);  chk("alr_ack_pulse", 32'({ifc.ack_alarma, ifc.ack_timer}), 0);
    ifc.alarm_req = 1'b0; ifc.timer_req = 1'b0; ifc.incrementar = 1'b0; tick(15);
    chk("alr_inc_cnt", n_inc - b_inc, 0);
    ifc.incrementar = 1'b1;
    tick(13); chk("alr_back_normal", 32'(ifc.evt_inc), 1);
    ifc.incrementar = 1'b0; tick(15);

    // alarm only
    b_est = n_est;
    ifc.alarm_req = 1'b1; ifc.establecer = 1'b1;
    tick(13); chk("alo_ack_a", 32'(ifc.ack_alarma), 1);
              chk("alo_ack_t", 32'(ifc.ack_timer), 0);
    ifc.alarm_req = 1'b0; ifc.establecer = 1'b0; tick(15);
    chk("alo_no_evt", n_est - b_est, 0);

    // timer request withdrawn before any press, then decrementar held
    ifc.timer_req = 1'b1; tick(3);
    ifc.timer_req = 1'b0; tick(2);
    b_dec = n_dec;
    ifc.decrementar = 1'b1;
    tick(13); chk("rep_t0", 32'(ifc.evt_dec), 1);
              chk("rep_dst", 32'(ifc.evt_dst), 3);
    errs = 0;
    for (int i = 1; i < 140; i++) begin
      tick(1);
`ifdef AUTO_REPEAT_EN
      exp_rep = (i == 50) || (i == 70) || (i == 90) || (i == 110);
`else
      exp_rep = 1'b0;
`endif
      if (ifc.evt_dec !== exp_rep) errs++;
      if (i == 108) ifc.decrementar = 1'b0;
    end
    chk("rep_pattern_errs", errs, 0);
`ifdef AUTO_REPEAT_EN
    chk("rep_count", n_dec - b_dec, 5);
`else
    chk("rep_count", n_dec - b_dec, 1);
`endif

    // reset in the middle of a held incrementar
    ifc.incrementar = 1'b1; tick(13 + 55);
    reset = 1'b1; #2;
    chk("rstm_modo", 32'(ifc.modo), 0);
    chk("rstm_outs", 32'({ifc.evt_inc, ifc.evt_dec, ifc.evt_cam, ifc.evt_est,
                          ifc.ack_alarma, ifc.ack_timer, ifc.bloqueo}), 0);
    ifc.incrementar = 1'b0;
    tick(3);
    b_inc = n_inc;
    reset = 1'b0;
    tick(12); chk("rstm_pre", 32'(ifc.modo), 0);
    tick(1);  chk("rstm_settle", 32'(ifc.modo), 3);
    tick(20); chk("rstm_no_stale", n_inc - b_inc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
